// File: rtl/irq_ctrl.sv
// irq_ctrl: six-source interrupt controller feeding CP0 HWint[5:0].
//
// Each raw source goes through a two-flop synchroniser. Its event (a rising
// edge or a level, chosen by EDGE_MASK) is latched into PEND and gated by
// ENABLE. A claim/complete handshake runs with fixed priority, where index 0
// is highest, and supports nesting through the in-service threshold.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous, active-high; clears all state
//   src        - raw interrupt sources, asynchronous to clk
//   bus_addr   - word index: 0 ENABLE, 1 PEND (W1C), 2 INSVC (RO), 3 CLAIM/COMPLETE
//   bus_we     - write strobe
//   bus_re     - read strobe; a read of CLAIM with bus_we low claims the best source
//   bus_wdata  - write data
//   bus_rdata  - read data, combinational from bus_addr
//   hwint      - registered one-hot of the highest-priority eligible source
module irq_ctrl #(
   parameter logic [5:0] EDGE_MASK = 6'b000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  src,
   input  logic [1:0]  bus_addr,
   input  logic        bus_we,
   input  logic        bus_re,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic [5:0]  hwint
);

   localparam int unsigned NSRC = 6;

   logic [5:0] s1, s2, s2_d;
   logic [5:0] pend, enable, insvc;

   logic [5:0] evt;
   logic [2:0] thr;
   logic [5:0] elig;
   logic       any_elig;
   logic [2:0] best;
   logic       claim_rd;
   logic [5:0] claim_vec;
   logic [5:0] w1c_vec;
   logic [5:0] complete_vec;
   logic [5:0] hwint_nxt;
   logic [2:0] cmp_id;
   logic       unused_wdata;

   assign unused_wdata = ^bus_wdata[31:6];
   assign cmp_id       = bus_wdata[2:0];

   // Edge sources see s2 & ~s2_d; level sources see s2 directly.
   assign evt = (EDGE_MASK & s2 & ~s2_d) | (~EDGE_MASK & s2);

   // A read that overlaps a write never claims.
   assign claim_rd = bus_re && !bus_we && (bus_addr == 2'd3);

   always_comb begin
      thr = 3'd6;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (insvc[i] && (thr == 3'd6)) thr = 3'(i);
      end

      elig = '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         elig[i] = pend[i] && enable[i] && (3'(i) < thr);
      end

      any_elig = |elig;
      best     = 3'd0;
      for (int unsigned i = NSRC; i > 0; i--) begin
         if (elig[i-1]) best = 3'(i - 1);
      end

      hwint_nxt = any_elig ? (6'b000001 << best) : '0;
      claim_vec = (claim_rd && any_elig) ? (6'b000001 << best) : '0;

      // W1C only reaches edge-triggered bits.
      w1c_vec = (bus_we && (bus_addr == 2'd1)) ? (bus_wdata[5:0] & EDGE_MASK) : '0;

      complete_vec = '0;
      if (bus_we && (bus_addr == 2'd3) && (cmp_id < 3'd6) && insvc[cmp_id]) begin
         complete_vec = 6'b000001 << cmp_id;
      end
   end

   always_comb begin
      bus_rdata = '0;
      case (bus_addr)
         2'd0: bus_rdata = {26'd0, enable};
         2'd1: bus_rdata = {26'd0, pend};
         2'd2: bus_rdata = {26'd0, insvc};
         2'd3: if (claim_rd && any_elig) bus_rdata = {1'b1, 28'd0, best};
         default: bus_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1     <= '0;
         s2     <= '0;
         s2_d   <= '0;
         pend   <= '0;
         enable <= '0;
         insvc  <= '0;
         hwint  <= '0;
      end else begin
         s1    <= src;
         s2    <= s1;
         s2_d  <= s2;
         // A new event wins over a same-cycle claim or W1C clear.
         pend  <= evt | (pend & ~claim_vec & ~w1c_vec);
         insvc <= (insvc | claim_vec) & ~complete_vec;
         hwint <= hwint_nxt;
         if (bus_we && (bus_addr == 2'd0)) enable <= bus_wdata[5:0];
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

   logic        clk;
   logic        reset;
   logic [5:0]  src;
   logic [1:0]  bus_addr;
   logic        bus_we;
   logic        bus_re;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic [5:0]  hwint;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   logic [31:0] obs;
   int          errors = 0;
   int          checks = 0;

   irq_ctrl #(.EDGE_MASK(6'b111110)) dut (
      .clk       (clk),
      .reset     (reset),
      .src       (src),
      .bus_addr  (bus_addr),
      .bus_we    (bus_we),
      .bus_re    (bus_re),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .hwint     (hwint)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Non-claiming read: no clock edge passes while the strobe is high.
   task automatic peek(input logic [1:0] a, output logic [31:0] d);
      bus_addr = a;
      bus_re   = 1'b1;
      #1;
      d        = bus_rdata;
      bus_re   = 1'b0;
   endtask

   task automatic claim(output logic [31:0] d);
      bus_addr = 2'd3;
      bus_re   = 1'b1;
      #1;
      d = bus_rdata;
      tick(1);
      bus_re = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus_addr  = a;
      bus_wdata = d;
      bus_we    = 1'b1;
      tick(1);
      bus_we    = 1'b0;
      bus_wdata = '0;
   endtask

   task automatic pulse(input int i);
      src[i] = 1'b1;
      tick(1);
      src[i] = 1'b0;
   endtask

   task automatic test_reset;
      sb.push_back('{tag:"rst_hwint", val:32'h0});
      sb.push_back('{tag:"rst_enable", val:32'h0});
      sb.push_back('{tag:"rst_pend", val:32'h0});
      sb.push_back('{tag:"rst_insvc", val:32'h0});
      obs = {26'd0, hwint};
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      for (int a = 0; a < 3; a++) begin
         peek(2'(a), obs);
         e = sb.pop_front(); checks++;
         if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      end
   endtask

   task automatic test_edge_claim;
      wr(2'd0, 32'h3F);
      sb.push_back('{tag:"edge_pend", val:32'h04});
      sb.push_back('{tag:"edge_hwint_early", val:32'h00});
      sb.push_back('{tag:"edge_hwint", val:32'h04});
      sb.push_back('{tag:"edge_claim", val:32'h80000002});
      sb.push_back('{tag:"edge_pend_after", val:32'h00});
      sb.push_back('{tag:"edge_insvc_after", val:32'h04});
      sb.push_back('{tag:"edge_hwint_after", val:32'h00});
      pulse(2);
      tick(2);
      peek(2'd1, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      obs = {26'd0, hwint};
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      tick(1);
      obs = {26'd0, hwint};
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      claim(obs);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      peek(2'd1, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      peek(2'd2, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      tick(1);
      obs = {26'd0, hwint};
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
   endtask

   // Source 2 is in service on entry.
   task automatic test_nesting;
      sb.push_back('{tag:"nest_hwint_low", val:32'h00});
      sb.push_back('{tag:"nest_hwint_high", val:32'h02});
      sb.push_back('{tag:"nest_claim1", val:32'h80000001});
      sb.push_back('{tag:"nest_insvc", val:32'h06});
      sb.push_back('{tag:"nest_hwint_blocked", val:32'h00});
      sb.push_back('{tag:"nest_insvc_done", val:32'h00});
      sb.push_back('{tag:"nest_hwint_resume", val:32'h10});
      sb.push_back('{tag:"nest_claim4", val:32'h80000004});
      pulse(4);
      tick(4);
      obs = {26'd0, hwint};
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      pulse(1);
      tick(3);
      obs = {26'd0, hwint};
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      claim(obs);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      peek(2'd2, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      wr(2'd3, 32'd1);
      tick(1);
      obs = {26'd0, hwint};
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      wr(2'd3, 32'd2);
      peek(2'd2, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      tick(1);
      obs = {26'd0, hwint};
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      claim(obs);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      wr(2'd3, 32'd4);
   endtask

   task automatic test_level;
      sb.push_back('{tag:"lvl_hwint", val:32'h01});
      sb.push_back('{tag:"lvl_claim", val:32'h80000000});
      sb.push_back('{tag:"lvl_hwint_insvc", val:32'h00});
      sb.push_back('{tag:"lvl_hwint_at_complete", val:32'h00});
      sb.push_back('{tag:"lvl_hwint_reassert", val:32'h01});
      sb.push_back('{tag:"lvl_insvc_final", val:32'h00});
      src[0] = 1'b1;
      tick(4);
      obs = {26'd0, hwint};
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      claim(obs);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      tick(3);
      obs = {26'd0, hwint};
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      wr(2'd3, 32'd0);
      obs = {26'd0, hwint};
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      tick(1);
      obs = {26'd0, hwint};
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      // Drop the level and drain: the claim clears PEND once no new event arrives.
      src[0] = 1'b0;
      tick(3);
      claim(obs);
      wr(2'd3, 32'd0);
      peek(2'd2, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
   endtask

   task automatic test_disabled;
      sb.push_back('{tag:"dis_pend", val:32'h08});
      sb.push_back('{tag:"dis_hwint", val:32'h00});
      sb.push_back('{tag:"dis_claim", val:32'h00});
      sb.push_back('{tag:"dis_pend_kept", val:32'h08});
      sb.push_back('{tag:"dis_w1c", val:32'h00});
      wr(2'd0, 32'h00);
      pulse(3);
      tick(2);
      peek(2'd1, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      tick(2);
      obs = {26'd0, hwint};
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      claim(obs);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      peek(2'd1, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      wr(2'd1, 32'h08);
      peek(2'd1, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
   endtask

   task automatic test_boundaries;
      sb.push_back('{tag:"w1c_vs_edge", val:32'h20});
      sb.push_back('{tag:"w1c_plain", val:32'h00});
      sb.push_back('{tag:"cmp_claim5", val:32'h80000005});
      sb.push_back('{tag:"cmp_id7", val:32'h20});
      sb.push_back('{tag:"cmp_not_insvc", val:32'h20});
      sb.push_back('{tag:"cmp_valid", val:32'h00});
      pulse(5);
      tick(3);
      // Second pulse: its event is live in the cycle that closes the W1C write.
      pulse(5);
      tick(1);
      wr(2'd1, 32'h20);
      peek(2'd1, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      wr(2'd1, 32'h20);
      peek(2'd1, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      wr(2'd0, 32'h3F);
      pulse(5);
      tick(3);
      claim(obs);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      wr(2'd3, 32'd7);
      peek(2'd2, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      wr(2'd3, 32'd3);
      peek(2'd2, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      wr(2'd3, 32'd5);
      peek(2'd2, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
   endtask

   task automatic test_async_reset;
      sb.push_back('{tag:"ar_insvc_before", val:32'h06});
      sb.push_back('{tag:"ar_enable", val:32'h00});
      sb.push_back('{tag:"ar_pend", val:32'h00});
      sb.push_back('{tag:"ar_insvc", val:32'h00});
      sb.push_back('{tag:"ar_hwint", val:32'h00});
      sb.push_back('{tag:"ar_stale_complete", val:32'h00});
      pulse(2);
      tick(3);
      claim(obs);
      pulse(1);
      tick(3);
      claim(obs);
      pulse(3);
      tick(3);
      peek(2'd2, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      #2;
      reset = 1'b1;
      #1;
      for (int a = 0; a < 3; a++) begin
         peek(2'(a), obs);
         e = sb.pop_front(); checks++;
         if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      end
      obs = {26'd0, hwint};
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
      tick(1);
      #2;
      reset = 1'b0;
      tick(1);
      wr(2'd3, 32'd1);
      peek(2'd2, obs);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val); end
   endtask

   initial begin
      reset     = 1'b1;
      src       = '0;
      bus_addr  = '0;
      bus_we    = 1'b0;
      bus_re    = 1'b0;
      bus_wdata = '0;
      tick(3);
      test_reset();
      #2;
      reset = 1'b0;
      tick(2);
      test_edge_claim();
      test_nesting();
      test_level();
      test_disabled();
      test_boundaries();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Six-source interrupt controller that sits between the peripherals (timers, bridge devices) and the CP0 `HWint[5:0]` input. It synchronises raw sources, latches pending events, applies software enables, and runs a claim/complete handshake with fixed priority and nesting. The exception handler reaches it through a small memory-mapped register window on the bridge.

## Interface
- `EDGE_MASK`, default `6'b000000`: bit i = 1 makes source i edge-triggered (rising edge); 0 makes it level-triggered.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `src` in 6: raw interrupt sources, asynchronous to `clk`.
- `bus_addr` in 2: word index. 0 = ENABLE, 1 = PEND, 2 = INSVC, 3 = CLAIM.
- `bus_we` in 1: write strobe.
- `bus_re` in 1: read strobe. Required for the CLAIM side effect.
- `bus_wdata` in 32: write data.
- `bus_rdata` out 32: read data, combinational from `bus_addr`.
- `hwint` out 6: registered; connects to CP0 `HWint`.

## Operation
- Synchroniser: two flops per source (`s1`, `s2`), plus `s2_d` for edge detection.
- Event detection:
  - Edge source: event = `s2 & ~s2_d`.
  - Level source: event = `s2`.
- PEND[i] update, in order of precedence:
  - Set on an event. Set wins over a same-cycle clear.
  - Otherwise cleared by a claim of i.
  - Otherwise cleared by a W1C write to PEND, edge sources only. W1C bits for level sources are ignored.
- ENABLE[5:0]: read/write, reset 0. A disabled source still latches PEND but is never presented or claimed.
- INSVC[5:0]: read-only. Set by claim, cleared by complete.
- Priority: index 0 is highest.
  - `thr` = lowest set index in INSVC, or 6 if INSVC = 0.
  - A source is eligible when PEND & ENABLE is set and its index < `thr`. This allows nesting: only strictly higher-priority sources preempt.
- `best` = lowest eligible index.
- `hwint` next = one-hot of `best`, or 0 if nothing is eligible. This is registered.
- CLAIM read (`bus_re`, addr 3, `bus_we` = 0):
  - `bus_rdata` = `{1'b1, 28'b0, best[2:0]}` if something is eligible, else 0.
  - At the clock edge when eligible: INSVC[best] is set and PEND[best] is cleared (unless a new event arrives the same cycle).
- COMPLETE write (`bus_we`, addr 3): `bus_wdata[2:0]` = id.
  - If id < 6 and INSVC[id] = 1, INSVC[id] is cleared.
  - Otherwise the write is ignored.
- Reads of addr 0/1/2 return the register zero-extended, with no side effects.
- `bus_we` and `bus_re` asserted together: the write is performed and the read causes no claim.
- Writes to INSVC (addr 2) are ignored.

## Timing
- Reset values: ENABLE = PEND = INSVC = 0, all synchroniser flops = 0, `hwint` = 0, `bus_rdata` = 0 for addr 1/2/3.
- A source already high at reset release is seen as an edge once it reaches `s2`.
- Latency: `src` rising before edge k gives `s1` at k, `s2` at k+1, PEND at k+2, `hwint` at k+3 (if enabled and above `thr`).
- Bus: `bus_rdata` is valid in the same cycle as `bus_re`. State changes from a read or write take effect at that cycle's closing edge.
- `hwint` drops one cycle after a claim (the claimed source is then in service), or one cycle after ENABLE is cleared.
- Level source held high: PEND re-sets the cycle after a claim. It is not re-presented until completed, because `thr` blocks it.
- Reset mid-handshake: INSVC is cleared, and an outstanding COMPLETE after reset is ignored.

## Test plan
- ENABLE = 0x3F, edge pulse on `src[2]` -> PEND = 0x04 and `hwint` = 0x04 three cycles later; CLAIM read returns 0x80000002; next cycle PEND = 0, INSVC = 0x04, `hwint` = 0.
- Nesting: while 2 is in service, pulse `src[4]` then `src[1]` -> `hwint` stays 0 for 4 and becomes 0x02 for 1. Claim 1, complete 1, complete 2 -> `hwint` = 0x10.
- Level `src[0]` held high, EDGE_MASK bit 0 = 0: claim, then complete -> `hwint` re-asserts 0x01 one cycle after the complete.
- ENABLE = 0: pulse `src[3]` -> PEND = 0x08 and `hwint` = 0, CLAIM returns 0. Write PEND = 0x08 (W1C) -> PEND = 0.
- Same-cycle W1C and new edge on source 5 -> PEND[5] remains 1. COMPLETE with id 7, or an id not in service -> INSVC unchanged.
- Assert `reset` asynchronously mid-cycle with INSVC = 0x06 -> all registers and `hwint` are 0 immediately, without waiting for a clock edge.
